rx_timer_ctrl: RTL and testbench

//  Bit-timing controller for the serial receive path. After a start-bit detect it sequences a
//  bit-period counter and a bit counter. It issues one shift_strobe at the centre of each data
//  bit and one packet_done pulse after the stop bit. It sits between the start-bit detector and
//  the receive shift register / packet buffer.

---
 rtl/rx_timer_ctrl_if.sv | 28 ++
 rtl/rx_timer_ctrl.sv | 101 ++++++++++
 tb/tb_rx_timer_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/rx_timer_ctrl_if.sv
// Handshake bundle between the start-bit detector, the serial line and the
// receive bit-timing controller.
interface rx_timer_ctrl_if;
    logic start_bit_detected;
    logic serial_in;
    logic shift_strobe;
    logic busy;
    logic packet_done;
    logic framing_error;

    modport master (
        output start_bit_detected,
        output serial_in,
        input  shift_strobe,
        input  busy,
        input  packet_done,
        input  framing_error
    );

    modport slave (
        input  start_bit_detected,
        input  serial_in,
        output shift_strobe,
        output busy,
        output packet_done,
        output framing_error
    );
endinterface

// File: rtl/rx_timer_ctrl.sv
// Receive bit-timing controller: start-bit centre check, data strobes, stop.
// Optional macro STOP_BIT_CHECK_EN adds a sticky framing_error flag.
module rx_timer_ctrl #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input logic            clk,
    input logic            n_rst,
    rx_timer_ctrl_if.slave bus
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_MID  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

    state_t        state;
    state_t        state_nx;
    logic [TW-1:0] timer;
    logic [BW-1:0] bit_cnt;
    logic          t_last;
    logic          t_mid;
    logic          timer_clr;
    logic          strobe;
    logic          busy_o;
    logic          done_o;

    assign t_last    = (timer == T_LAST);
    assign t_mid     = (timer == T_MID);
    assign timer_clr = (state == IDLE) || (state_nx != state) || t_last;

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state decode; start pulses only matter in IDLE
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (bus.start_bit_detected) state_nx = START;
            START: if (t_mid) state_nx = bus.serial_in ? IDLE : DATA;
            DATA:  if (t_last && bit_cnt == B_LAST) state_nx = STOP;
            STOP:  if (t_last) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from registered state and timer only
    always_comb begin
        strobe = 1'b0;
        busy_o = 1'b1;
        done_o = 1'b0;
        unique case (1'b1)
            (state == IDLE): busy_o = 1'b0;
            (state == DATA): strobe = t_last;
            (state == DONE): done_o = 1'b1;
            default: ;
        endcase
    end

    // Bit-period timer: clears on entry to each state and on wrap
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)         timer <= '0;
        else if (timer_clr) timer <= '0;
        else                timer <= timer + TW'(1);
    end

    // Data bit counter: advances on each strobe, cleared outside DATA
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)             bit_cnt <= '0;
        else if (state != DATA) bit_cnt <= '0;
        else if (strobe)        bit_cnt <= (bit_cnt == B_LAST) ? '0 : bit_cnt + BW'(1);
    end

`ifdef STOP_BIT_CHECK_EN
    logic fe;

    // Sticky stop-bit error, cleared when a new frame is accepted
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            fe <= 1'b0;
        else if (state == IDLE && bus.start_bit_detected)
            fe <= 1'b0;
        else if (state == STOP && t_last && !bus.serial_in)
            fe <= 1'b1;
    end

    assign bus.framing_error = fe;
`else
    assign bus.framing_error = 1'b0;
`endif

    assign bus.shift_strobe = strobe;
    assign bus.busy         = busy_o;
    assign bus.packet_done  = done_o;
endmodule

// File: tb/tb_rx_timer_ctrl.sv
// Self-checking bench for rx_timer_ctrl: offset-based frame model plus
// directed frames (clean, false start, back-to-back, abort, stop error).
module tb_rx_timer_ctrl;
    localparam int C    = 10;
    localparam int D    = 8;
    localparam int H    = C / 2;
    localparam int ENDK = H + (D + 1) * C;
`ifdef STOP_BIT_CHECK_EN
    localparam bit FE_ON = 1'b1;
`else
    localparam bit FE_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    rx_timer_ctrl_if bus();

    rx_timer_ctrl #(.CLKS_PER_BIT(C), .DATA_BITS(D)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model: frame start edge e, false-start flag, sticky error
    int cyc = 0;
    int e   = 0;
    bit act = 1'b0;
    bit fls = 1'b0;
    bit mfe = 1'b0;

    int seen_s[$];
    int seen_d[$];
    int fall = -1;

    function automatic bit m_busy(int k);
        int last;
        last = fls ? H - 1 : ENDK;
        return act && k >= 0 && k <= last;
    endfunction

    task automatic chk(string nm, logic a, logic x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, a, x);
        end
    endtask

    task automatic chki(string nm, int a, int x);
        total++;
        if (a != x) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, a, x);
        end
    endtask

    // model update at each active edge from the sampled inputs
    always @(posedge clk) begin
        bit pb;
        cyc++;
        if (!n_rst) begin
            act = 1'b0;
            fls = 1'b0;
            mfe = 1'b0;
        end else begin
            pb = m_busy(cyc - 1 - e);
            if (act && !fls && cyc - e == H && bus.serial_in)
                fls = 1'b1;
            if (FE_ON && act && !fls && cyc - e == ENDK && !bus.serial_in)
                mfe = 1'b1;
            if (!pb && bus.start_bit_detected) begin
                act = 1'b1;
                fls = 1'b0;
                e   = cyc;
                mfe = 1'b0;
            end
        end
    end

    // compare every cycle on the falling edge
    always @(negedge clk) begin
        int k;
        bit eb, es, ed, ef;
        k  = cyc - e;
        eb = 1'b0;
        es = 1'b0;
        ed = 1'b0;
        ef = 1'b0;
        if (n_rst) begin
            eb = m_busy(k);
            es = act && !fls && k >= H && k < H + D * C
                 && ((k - H) % C) == C - 1;
            ed = act && !fls && k == ENDK;
            ef = mfe;
        end
        chk("busy", bus.busy, eb);
        chk("shift_strobe", bus.shift_strobe, es);
        chk("packet_done", bus.packet_done, ed);
        chk("framing_error", bus.framing_error, ef);
        if (bus.shift_strobe === 1'b1) seen_s.push_back(k);
        if (bus.packet_done === 1'b1) seen_d.push_back(k);
        if (fall < 0 && bus.busy === 1'b0) fall = k;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear();
        seen_s.delete();
        seen_d.delete();
        fall = -1;
    endtask

    task automatic pulse(input logic sv);
        bus.start_bit_detected = 1'b1;
        bus.serial_in = sv;
        tick();
        bus.start_bit_detected = 1'b0;
        clear();
    endtask

    task automatic body(input int nk, input logic sv, input logic stopv,
                        input int x1, input int x2, input logic [7:0] d);
        for (int i = 0; i < nk; i++) begin
            int s;
            s = i + 1;
            if (s <= H)
                bus.serial_in = sv;
            else if (s <= H + D * C)
                bus.serial_in = d[(s - H - 1) / C];
            else
                bus.serial_in = stopv;
            bus.start_bit_detected = (s == x1) || (s == x2);
            tick();
        end
        bus.start_bit_detected = 1'b0;
        bus.serial_in = 1'b1;
    endtask

    task automatic chk_clean(string tag);
        chki({tag, "_nstrobe"}, seen_s.size(), 8);
        chki({tag, "_first"}, seen_s.size() > 0 ? seen_s[0] : -1, 14);
        chki({tag, "_last"}, seen_s.size() > 7 ? seen_s[7] : -1, 84);
        chki({tag, "_ndone"}, seen_d.size(), 1);
        chki({tag, "_done_at"}, seen_d.size() > 0 ? seen_d[0] : -1, 95);
        chki({tag, "_busy_fall"}, fall, 96);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bus.start_bit_detected = 1'b0;
        bus.serial_in = 1'b1;

        // reset with random inputs
        for (int i = 0; i < 6; i++) begin
            bus.start_bit_detected = 1'($urandom_range(0, 1));
            bus.serial_in = 1'($urandom_range(0, 1));
            tick();
        end
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.packet_done, 1'b0);
        n_rst = 1'b1;
        bus.start_bit_detected = 1'b0;
        bus.serial_in = 1'b1;
        repeat (3) tick();

        // clean frame
        pulse(1'b0);
        body(100, 1'b0, 1'b1, -1, -1, 8'hA5);
        chk_clean("clean");

        // false start
        pulse(1'b1);
        body(20, 1'b1, 1'b1, -1, -1, 8'hFF);
        chki("false_nstrobe", seen_s.size(), 0);
        chki("false_ndone", seen_d.size(), 0);
        chki("false_busy_fall", fall, H);

        // back-to-back: pulse in DATA ignored, pulse in first IDLE accepted
        pulse(1'b0);
        body(97, 1'b0, 1'b1, 40, 97, 8'h3C);
        chk_clean("b2b_a");
        clear();
        body(100, 1'b0, 1'b1, -1, -1, 8'hC3);
        chk_clean("b2b_b");

        // pulse during the DONE cycle is dropped
        pulse(1'b0);
        body(110, 1'b0, 1'b1, 96, -1, 8'h5A);
        chk_clean("done_ign");

        // abort mid-frame
        pulse(1'b0);
        body(39, 1'b0, 1'b1, -1, -1, 8'h0F);
        n_rst = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_strobe", bus.shift_strobe, 1'b0);
        tick();
        n_rst = 1'b1;
        repeat (70) tick();
        chki("abort_ndone", seen_d.size(), 0);
        chk("abort_idle", bus.busy, 1'b0);

        // bad stop bit
        pulse(1'b0);
        body(100, 1'b0, 1'b0, -1, -1, 8'h81);
        chk_clean("stop0");
        chk("fe_sticky", bus.framing_error, FE_ON);
        pulse(1'b0);
        chk("fe_cleared", bus.framing_error, 1'b0);
        body(100, 1'b0, 1'b1, -1, -1, 8'h7E);
        chk_clean("after_fe");
        chk("fe_good_stop", bus.framing_error, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
